// File: rtl/reduce_arbiter_if.sv
// reduce_arbiter_if: request/operand inputs and registered result handshake for reduce_arbiter
interface reduce_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 4
);
   localparam int ID_W = NREQ > 1 ? $clog2(NREQ) : 1;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] operand;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  res_valid;
   logic                  res_ready;
   logic [ID_W-1:0]       res_id;
   logic                  res_and;
   logic                  res_nand;
   logic                  res_or;
   logic                  res_nor;
   logic                  res_xor;
   logic                  res_xnor;
   modport master (
      output req, operand, res_ready,
      input  gnt, busy, res_valid, res_id,
      input  res_and, res_nand, res_or, res_nor, res_xor, res_xnor
   );
   modport slave (
      input  req, operand, res_ready,
      output gnt, busy, res_valid, res_id,
      output res_and, res_nand, res_or, res_nor, res_xor, res_xnor
   );
endinterface

// File: rtl/reduce_arbiter.sv
// reduce_arbiter: round-robin shared bit-serial engine producing AND/NAND/OR/NOR/XOR/XNOR of one operand at a time
module reduce_arbiter #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 4
) (
   input logic             clk,
   input logic             rst,
   reduce_arbiter_if.slave bus
);
   localparam int ID_W = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int CW   = WIDTH > 1 ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} stateType;

   stateType        state, nextState;
   logic [ID_W-1:0] ptr, winner;
   logic            anyReq;
   logic [WIDTH-1:0] shReg;
   logic [CW-1:0]   count;
   logic            accAnd, accOr, accXor;
   logic            capture, lastBit, handshake, bit0;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      winner = '0;
      anyReq = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req[(int'(ptr) + k) % NREQ]) begin
            winner = ID_W'((int'(ptr) + k) % NREQ);
            anyReq = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = anyReq ? RUN : IDLE;
         RUN:     nextState = lastBit ? HOLD : RUN;
         HOLD:    nextState = bus.res_ready ? IDLE : HOLD;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      capture   = state == IDLE && anyReq;
      lastBit   = state == RUN && count == CW'(WIDTH - 1);
      handshake = state == HOLD && bus.res_ready;
      bit0      = shReg[0];
   end

   assign bus.busy = state != IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr           <= '0;
         shReg         <= '0;
         count         <= '0;
         accAnd        <= 1'b0;
         accOr         <= 1'b0;
         accXor        <= 1'b0;
         bus.gnt       <= '0;
         bus.res_valid <= 1'b0;
         bus.res_id    <= '0;
         bus.res_and   <= 1'b0;
         bus.res_nand  <= 1'b0;
         bus.res_or    <= 1'b0;
         bus.res_nor   <= 1'b0;
         bus.res_xor   <= 1'b0;
         bus.res_xnor  <= 1'b0;
      end else begin
         bus.gnt <= NREQ'(capture) << winner;
         if (capture) begin
            shReg      <= bus.operand[int'(winner)*WIDTH +: WIDTH];
            bus.res_id <= winner;
            count      <= '0;
            accAnd     <= 1'b1;
            accOr      <= 1'b0;
            accXor     <= 1'b0;
         end
         if (state == RUN) begin
            accAnd <= accAnd & bit0;
            accOr  <= accOr | bit0;
            accXor <= accXor ^ bit0;
            shReg  <= shReg >> 1;
            count  <= count + 1'b1;
         end
         // The final bit folds straight into the result registers, saving a cycle.
         if (lastBit) begin
            bus.res_valid <= 1'b1;
            bus.res_and   <= accAnd & bit0;
            bus.res_nand  <= ~(accAnd & bit0);
            bus.res_or    <= accOr | bit0;
            bus.res_nor   <= ~(accOr | bit0);
            bus.res_xor   <= accXor ^ bit0;
            bus.res_xnor  <= ~(accXor ^ bit0);
         end
         if (handshake) begin
            bus.res_valid <= 1'b0;
            ptr           <= ID_W'((int'(bus.res_id) + 1) % NREQ);
         end
      end
   end
endmodule

// File: tb/tb_reduce_arbiter.sv
// tb_reduce_arbiter: directed and randomized checks of reduce_arbiter against a transaction-level reference
module tb_reduce_arbiter;
   localparam int NREQ  = 2;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nAsserts = 0;
   int   nFail = 0;
   int   cyc = 0;
   int   ptr = 0;
   int   lastCap = -1;

   reduce_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
   reduce_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] outs();
      return {bus.gnt, bus.busy, bus.res_valid, bus.res_id, bus.res_and, bus.res_nand,
              bus.res_or, bus.res_nor, bus.res_xor, bus.res_xnor};
   endfunction

   function automatic logic [5:0] res6();
      return {bus.res_and, bus.res_nand, bus.res_or, bus.res_nor, bus.res_xor, bus.res_xnor};
   endfunction

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // One complete operation from IDLE: capture, WIDTH run cycles, optional stall, handshake.
   task automatic op(input logic [1:0] reqv, input logic [1:0] reqAfter, input logic [3:0] o0,
                     input logic [3:0] o1, input int holdCycles, input bit chkPeriod);
      int         w;
      logic [3:0] v;
      logic [5:0] exp6;
      w    = pick(reqv, ptr);
      v    = (w == 1) ? o1 : o0;
      exp6 = {&v, ~&v, |v, ~|v, ^v, ~^v};
      bus.req       = reqv;
      bus.operand   = {o1, o0};
      bus.res_ready = (holdCycles == 0);
      step();
      chk("gnt", bus.gnt, 32'(1 << w));
      chk("busyRun", bus.busy, 1);
      chk("validRun", bus.res_valid, 0);
      if (chkPeriod) chk("period", cyc - lastCap, WIDTH + 2);
      lastCap     = cyc;
      bus.req     = reqAfter;
      bus.operand = 8'($urandom);
      repeat (WIDTH - 1) begin
         step();
         chk("runQuiet", {bus.gnt, bus.res_valid, bus.busy}, 3'b001);
      end
      step();
      chk("resValid", bus.res_valid, 1);
      chk("resId", bus.res_id, w);
      chk("res6", res6(), exp6);
      repeat (holdCycles) begin
         step();
         chk("hold", {bus.gnt, bus.busy, bus.res_valid, bus.res_id, res6()}, {2'b00, 1'b1, 1'b1, 1'(w), exp6});
      end
      bus.res_ready = 1'b1;
      step();
      chk("handshake", {bus.gnt, bus.busy, bus.res_valid, bus.res_id, res6()}, {2'b00, 1'b0, 1'b0, 1'(w), exp6});
      ptr = (w + 1) % NREQ;
   endtask

   initial begin
      bus.req       = 2'b11;
      bus.operand   = 8'hff;
      bus.res_ready = 1'b0;
      rst           = 1'b1;
      step();
      chk("reset1", outs(), 0);
      step();
      chk("reset2", outs(), 0);
      bus.req = 2'b00;
      rst     = 1'b0;
      step();
      chk("idleAfterReset", outs(), 0);

      op(2'b01, 2'b00, 4'b0000, 4'b1010, 0, 1'b0);

      op(2'b10, 2'b00, 4'b0110, 4'b1111, 0, 1'b0);
      op(2'b10, 2'b00, 4'b0110, 4'b0001, 0, 1'b0);
      op(2'b10, 2'b00, 4'b0110, 4'b0011, 0, 1'b0);
      op(2'b10, 2'b00, 4'b0110, 4'b0111, 0, 1'b0);

      op(2'b01, 2'b00, 4'b0101, 4'b0000, 0, 1'b0);
      op(2'b10, 2'b00, 4'b0101, 4'b1110, 0, 1'b0);

      op(2'b11, 2'b11, 4'($urandom), 4'($urandom), 0, 1'b0);
      op(2'b11, 2'b11, 4'($urandom), 4'($urandom), 0, 1'b1);
      op(2'b11, 2'b11, 4'($urandom), 4'($urandom), 0, 1'b1);
      op(2'b11, 2'b00, 4'($urandom), 4'($urandom), 0, 1'b1);

      op(2'b01, 2'b10, 4'b1011, 4'b0100, 5, 1'b0);
      op(2'b10, 2'b00, 4'b1011, 4'b0100, 0, 1'b0);

      op(2'b01, 2'b00, 4'b1100, 4'b0000, 0, 1'b0);
      bus.req     = 2'b01;
      bus.operand = 8'h0f;
      step();
      chk("abortGnt", bus.gnt, 2'b01);
      bus.req = 2'b00;
      step();
      rst = 1'b1;
      step();
      chk("abortReset", outs(), 0);
      rst = 1'b0;
      ptr = 0;
      repeat (WIDTH + 2) begin
         step();
         chk("abortNoValid", {bus.res_valid, bus.busy}, 2'b00);
      end
      op(2'b11, 2'b00, 4'b1001, 4'b0110, 0, 1'b0);

      repeat (20) begin
         op(2'($urandom_range(1, 3)), 2'b00, 4'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            step();
            chk("idleGap", {bus.gnt, bus.busy, bus.res_valid}, 4'b0000);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end
endmodule
